// File: rtl/setup_hold_monitor_if.sv
// Signal bundle between a stimulus source and the setup/hold monitor.
// The master drives the monitored clock/data and enable; the slave reports violations.
interface setup_hold_monitor_if #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8,
    parameter int TS_W  = 16
);
    logic             en;
    logic             chk_clk;
    logic [WIDTH-1:0] d;
    logic             setup_viol;
    logic             hold_viol;
    logic [CNT_W-1:0] viol_count;
    logic [TS_W-1:0]  last_viol_ts;
    logic [1:0]       state;

    modport master (
        output en, chk_clk, d,
        input  setup_viol, hold_viol, viol_count, last_viol_ts, state
    );

    modport slave (
        input  en, chk_clk, d,
        output setup_viol, hold_viol, viol_count, last_viol_ts, state
    );
endinterface

// File: rtl/setup_hold_monitor.sv
// Oversamples a monitored clock and data bus on clk and flags setup/hold window
// violations, with a saturating violation count and a timestamp of the latest one.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  IDLE     | disarmed (en=0 or just out of reset), no checking
//  ARMED    | waiting for a chk_clk rise; setup checked on each rise
//  HOLD_WIN | hold window open after a rise; first data change is flagged
module setup_hold_monitor #(
    parameter int WIDTH     = 2,
    parameter int SETUP_CYC = 3,
    parameter int HOLD_CYC  = 2,
    parameter int CNT_W     = 8,
    parameter int TS_W      = 16
) (
    input logic                 clk,
    input logic                 rst,
    setup_hold_monitor_if.slave mon
);
    localparam int SC_W = $clog2(SETUP_CYC + 1);
    localparam int HC_W = $clog2(HOLD_CYC + 1);
    localparam logic [SC_W-1:0] SETUP_MAX = SC_W'(SETUP_CYC);
    localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_CYC);
    localparam logic [HC_W-1:0] HOLD_TC   = HC_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ARMED    = 2'b01,
        HOLD_WIN = 2'b10
    } state_t;

    state_t           st;
    logic             s1_clk, s2_clk;
    logic [WIDTH-1:0] s1_d, s2_d;
    logic [TS_W-1:0]  ts;
    logic [SC_W-1:0]  since_chg;
    logic [HC_W-1:0]  hold_cnt;
    logic             hold_seen;
    logic             setup_viol_q, hold_viol_q;
    logic [CNT_W-1:0] viol_count_q;
    logic [TS_W-1:0]  last_viol_ts_q;

    logic rise, chg, checking, setup_det, hold_det;

    always_comb begin
        rise      = s1_clk & ~s2_clk;
        chg       = (s1_d != s2_d);
        checking  = mon.en && ((st == ARMED) || (st == HOLD_WIN));
        setup_det = checking && rise && (chg || (since_chg < SETUP_MAX));
        // A change coincident with a rise belongs to the setup side only.
        hold_det  = mon.en && (st == HOLD_WIN) && !rise && chg && !hold_seen;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st             <= IDLE;
            s1_clk         <= 1'b0;
            s2_clk         <= 1'b0;
            s1_d           <= '0;
            s2_d           <= '0;
            ts             <= '0;
            since_chg      <= SETUP_MAX;
            hold_cnt       <= '0;
            hold_seen      <= 1'b0;
            setup_viol_q   <= 1'b0;
            hold_viol_q    <= 1'b0;
            viol_count_q   <= '0;
            last_viol_ts_q <= '0;
        end else begin
            s1_clk <= mon.chk_clk;
            s2_clk <= s1_clk;
            s1_d   <= mon.d;
            s2_d   <= s1_d;
            ts     <= ts + 1'b1;

            if (chg)
                since_chg <= '0;
            else if (since_chg != SETUP_MAX)
                since_chg <= since_chg + 1'b1;

            setup_viol_q <= setup_det;
            hold_viol_q  <= hold_det;
            if (setup_det || hold_det) begin
                if (viol_count_q != '1)
                    viol_count_q <= viol_count_q + 1'b1;
                last_viol_ts_q <= ts;
            end

            if (!mon.en) begin
                st        <= IDLE;
                hold_cnt  <= '0;
                hold_seen <= 1'b0;
            end else begin
                case (st)
                    IDLE: st <= ARMED;
                    ARMED: begin
                        if (rise) begin
                            st        <= HOLD_WIN;
                            hold_cnt  <= HOLD_LOAD;
                            hold_seen <= 1'b0;
                        end
                    end
                    HOLD_WIN: begin
                        if (rise) begin
                            hold_cnt  <= HOLD_LOAD;
                            hold_seen <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                            if (hold_det)
                                hold_seen <= 1'b1;
                            if (hold_cnt == HOLD_TC)
                                st <= ARMED;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

    assign mon.setup_viol   = setup_viol_q;
    assign mon.hold_viol    = hold_viol_q;
    assign mon.viol_count   = viol_count_q;
    assign mon.last_viol_ts = last_viol_ts_q;
    assign mon.state        = st;
endmodule
